sun_centroid_apb: RTL and testbench
===================================

SUN_CENTROID_APB -- requirements
Module: sun_centroid_apb

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel intensity width.
REQ-002 SHALL have parameter CNT_W, default 10: coordinate counter width; XMAX/YMAX range 1..2^CNT_W-1.
REQ-003 SHALL have parameter ACC_W, default 32, legal 24..32: accumulator, I_TOTAL and divider width.
REQ-004 SHALL have ports: pclk  in  1  clock; presetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: psels in 1 select; penables in 1 enable; pwrites in 1 write; paddrs in 32 address; pwdatas in 32 write data.
REQ-006 SHALL have ports: prdatas out 32 read data; preadys out 1 ready; irqs out 1 done interrupt, present only with SUN_CENTROID_IRQ_EN.

Function
REQ-007 SHALL decode paddrs[7:0] (word offsets): 0x00 CTRL W, 0x01 THRESH RW, 0x02 XMAX RW, 0x03 YMAX RW, 0x04 PIXEL W, 0x05 STATUS R, 0x06 SUMX R, 0x07 SUMY R, 0x08 H R, 0x09 K R, 0x0A ITOTAL R; other offsets: writes ignored, reads 0.
REQ-008 SHALL treat psels=1, penables=0 as setup phase and psels=1, penables=1 as access phase; preadys SHALL be high for every access phase (zero wait states), low otherwise.
REQ-009 SHALL commit writes on the pclk edge ending the access phase; prdatas SHALL carry zero-extended register data during read access phases, else 0.
REQ-010 SHALL implement FSM IDLE, ACCUM, DIV, DONE.
REQ-011 CTRL bit0=1 write (START) from any state SHALL clear SUMX, SUMY, ITOTAL, H, K, counters, flags; xcount=1, ycount=1; then enter ACCUM (aborting any frame or division).
REQ-012 START with XMAX=0 or YMAX=0 SHALL set STATUS.cfg_err, remain in IDLE.
REQ-013 PIXEL write in ACCUM: v = (pwdatas[PIX_W-1:0] > THRESH) ? pixel : 0; SUMX += v*xcount; SUMY += v*ycount; ITOTAL += v; all in the same edge.
REQ-014 Strict compare: pixel == THRESH SHALL contribute 0.
REQ-015 After each accepted pixel: xcount==XMAX -> xcount=1, ycount+1; else xcount+1; pixel with xcount==XMAX and ycount==YMAX SHALL move FSM to DIV next cycle.
REQ-016 PIXEL write in IDLE, DIV or DONE SHALL be discarded and set sticky STATUS.drop.
REQ-017 Accumulator add exceeding 2^ACC_W-1 SHALL saturate to all-ones and set sticky STATUS.ovf.
REQ-018 DIV with ITOTAL=0 SHALL set H=K=0, STATUS.zero, enter DONE next cycle.
REQ-019 DIV otherwise SHALL run a sequential restoring divider, one quotient bit per cycle, H=SUMX/ITOTAL and K=SUMY/ITOTAL in parallel, DONE exactly ACC_W cycles after DIV entry; H, K truncated to CNT_W.
REQ-020 THRESH/XMAX/YMAX writes during ACCUM or DIV SHALL be ignored.
REQ-021 STATUS bits: 0 idle, 1 accum, 2 div, 3 done, 4 ovf, 5 zero, 6 drop, 7 cfg_err.
REQ-022 CTRL bit2=1 write SHALL clear STATUS bits 4-7 and return DONE to IDLE.

Reset
REQ-023 presetn=0 SHALL immediately force: FSM IDLE; all registers, counters, flags 0; prdatas=0; preadys=0; irqs=0; including mid-frame and mid-division.
REQ-024 Deassertion SHALL take effect on the next pclk edge; no APB transfer is accepted while presetn=0.

Configuration
REQ-025 With SUN_CENTROID_IRQ_EN defined: CTRL bit1 is a readable-back irq_en; irqs SHALL pulse high one cycle on DIV->DONE when irq_en=1.
REQ-026 Without SUN_CENTROID_IRQ_EN: irqs port and irq_en absent; CTRL bit1 ignored; completion observable only via STATUS.done polling.

Verification
REQ-027 THRESH=10, XMAX=2, YMAX=2, START, pixels 0,20,0,40 -> SUMX=120, SUMY=100, ITOTAL=60, DONE 32 cycles after last pixel, H=2, K=1, STATUS=0x08.
REQ-028 THRESH=50, XMAX=1, YMAX=1, START, pixel 50 -> ITOTAL=0, STATUS.zero=1, H=K=0, DONE one cycle after DIV entry.
REQ-029 PIXEL write 0x33 before START -> STATUS=0x41 (idle+drop), SUMX unchanged 0; CTRL=0x04 -> STATUS=0x01.
REQ-030 ACC_W=24, THRESH=0, XMAX=1023, YMAX=1023, pixels all 255 -> STATUS.ovf=1, SUMX=0xFFFFFF.
REQ-031 presetn low during DIV cycle 10 -> all outputs 0 immediately; after release STATUS=0x01, reads of H/K/SUMX return 0.
REQ-032 With SUN_CENTROID_IRQ_EN, CTRL=0x03 then REQ-027 frame -> irqs high exactly one cycle at DONE entry; with CTRL=0x01 irqs stays 0.

Source files
------------

// File: rtl/sun_centroid_apb.sv
// sun_centroid_apb -- sun-sensor intensity centroid engine with an APB slave.
//
// Pixels are streamed in raster order through the PIXEL register. Each pixel
// above THRESH is accumulated into SUMX (v*x), SUMY (v*y) and ITOTAL (v).
// After the last pixel of an XMAX x YMAX frame, a restoring divider produces
// H = SUMX/ITOTAL and K = SUMY/ITOTAL.
//
// Ports:
//   pclk, presetn          clock, asynchronous active-low reset
//   psels, penables        APB select / enable
//   pwrites                APB direction (1 = write)
//   paddrs[31:0]           word offset in bits [7:0]
//   pwdatas[31:0]          write data
//   prdatas[31:0]          read data (0 outside read access phases)
//   preadys                high on every access phase (no wait states)
//   irqs                   one-cycle done pulse (only with SUN_CENTROID_IRQ_EN)
//
// Build option: define SUN_CENTROID_IRQ_EN to add the irqs port and the
// CTRL.irq_en bit (CTRL bit1).
//
// FSM states:
//   state   | meaning
//   S_IDLE  | waiting for START
//   S_ACCUM | accepting pixels of the current frame
//   S_DIV   | dividing sums by ITOTAL, one quotient bit per cycle
//   S_DONE  | H/K valid, waiting for START or CTRL clear
module sun_centroid_apb #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 10,
    parameter int ACC_W = 32
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psels,
    input  logic        penables,
    input  logic        pwrites,
    input  logic [31:0] paddrs,
    input  logic [31:0] pwdatas,
    output logic [31:0] prdatas,
    output logic        preadys
`ifdef SUN_CENTROID_IRQ_EN
    ,
    output logic        irqs
`endif
);

    localparam int AW1  = ACC_W + 1;
    localparam int DC_W = $clog2(ACC_W);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(ACC_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_THRESH = 8'h01;
    localparam logic [7:0] A_XMAX   = 8'h02;
    localparam logic [7:0] A_YMAX   = 8'h03;
    localparam logic [7:0] A_PIXEL  = 8'h04;
    localparam logic [7:0] A_STATUS = 8'h05;
    localparam logic [7:0] A_SUMX   = 8'h06;
    localparam logic [7:0] A_SUMY   = 8'h07;
    localparam logic [7:0] A_H      = 8'h08;
    localparam logic [7:0] A_K      = 8'h09;
    localparam logic [7:0] A_ITOTAL = 8'h0A;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIV, S_DONE} state_t;

    state_t             state_q;
    logic [PIX_W-1:0]   thresh_q;
    logic [CNT_W-1:0]   xmax_q, ymax_q, xcnt_q, ycnt_q, h_q, k_q;
    logic [ACC_W-1:0]   sumx_q, sumy_q, itot_q;
    logic [ACC_W-1:0]   rem_x_q, rem_y_q, quot_x_q, quot_y_q;
    logic [DC_W-1:0]    divcnt_q;
    logic               ovf_q, zero_q, drop_q, cfg_err_q;
    logic               irq_en_q, irq_q;

    logic               acc_ph, wr_en, rd_en;
    logic [7:0]         addr;
    logic [PIX_W-1:0]   pix, pix_v;
    logic [ACC_W:0]     add_x, add_y, add_t;
    logic [ACC_W-1:0]   sumx_nx, sumy_nx, itot_nx;
    logic               acc_ovf;
    logic [ACC_W:0]     div1, trial_x, trial_y, diff_x, diff_y;
    logic               qb_x, qb_y;
    logic [ACC_W-1:0]   rem_x_nx, rem_y_nx, quot_x_nx, quot_y_nx;
    logic [7:0]         status_c;
    logic [31:0]        rdata_c;
    logic               unused_bits;

    assign acc_ph  = psels & penables;
    assign wr_en   = acc_ph & pwrites;
    assign rd_en   = acc_ph & ~pwrites;
    assign addr    = paddrs[7:0];
    // Gated by presetn so both outputs drop the instant reset asserts.
    assign preadys = acc_ph & presetn;
    assign prdatas = (rd_en & presetn) ? rdata_c : 32'h0;

`ifdef SUN_CENTROID_IRQ_EN
    assign irqs = irq_q;
`endif

    // Accumulation datapath with saturation on carry-out.
    always_comb begin
        pix     = pwdatas[PIX_W-1:0];
        pix_v   = (pix > thresh_q) ? pix : '0;
        add_x   = {1'b0, sumx_q} + AW1'(pix_v) * AW1'(xcnt_q);
        add_y   = {1'b0, sumy_q} + AW1'(pix_v) * AW1'(ycnt_q);
        add_t   = {1'b0, itot_q} + AW1'(pix_v);
        sumx_nx = add_x[ACC_W] ? '1 : add_x[ACC_W-1:0];
        sumy_nx = add_y[ACC_W] ? '1 : add_y[ACC_W-1:0];
        itot_nx = add_t[ACC_W] ? '1 : add_t[ACC_W-1:0];
        acc_ovf = add_x[ACC_W] | add_y[ACC_W] | add_t[ACC_W];
    end

    // Restoring divider step: the dividend bit is taken straight from the
    // (frozen) sum register, so no separate dividend shifter is needed.
    always_comb begin
        div1      = {1'b0, itot_q};
        trial_x   = {rem_x_q, sumx_q[divcnt_q]};
        trial_y   = {rem_y_q, sumy_q[divcnt_q]};
        diff_x    = trial_x - div1;
        diff_y    = trial_y - div1;
        qb_x      = (trial_x >= div1);
        qb_y      = (trial_y >= div1);
        rem_x_nx  = qb_x ? diff_x[ACC_W-1:0] : trial_x[ACC_W-1:0];
        rem_y_nx  = qb_y ? diff_y[ACC_W-1:0] : trial_y[ACC_W-1:0];
        quot_x_nx = {quot_x_q[ACC_W-2:0], qb_x};
        quot_y_nx = {quot_y_q[ACC_W-2:0], qb_y};
    end

    always_comb begin
        status_c = {cfg_err_q, drop_q, zero_q, ovf_q,
                    state_q == S_DONE, state_q == S_DIV,
                    state_q == S_ACCUM, state_q == S_IDLE};
        rdata_c  = 32'h0;
        case (addr)
            A_CTRL:   rdata_c = {30'h0, irq_en_q, 1'b0};
            A_THRESH: rdata_c = 32'(thresh_q);
            A_XMAX:   rdata_c = 32'(xmax_q);
            A_YMAX:   rdata_c = 32'(ymax_q);
            A_STATUS: rdata_c = 32'(status_c);
            A_SUMX:   rdata_c = 32'(sumx_q);
            A_SUMY:   rdata_c = 32'(sumy_q);
            A_H:      rdata_c = 32'(h_q);
            A_K:      rdata_c = 32'(k_q);
            A_ITOTAL: rdata_c = 32'(itot_q);
            default:  rdata_c = 32'h0;
        endcase
    end

    assign unused_bits = ^{paddrs[31:8], pwdatas, diff_x[ACC_W], diff_y[ACC_W],
                           quot_x_q[ACC_W-1], quot_y_q[ACC_W-1]};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            thresh_q  <= '0;
            xmax_q    <= '0;
            ymax_q    <= '0;
            xcnt_q    <= '0;
            ycnt_q    <= '0;
            h_q       <= '0;
            k_q       <= '0;
            sumx_q    <= '0;
            sumy_q    <= '0;
            itot_q    <= '0;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            quot_x_q  <= '0;
            quot_y_q  <= '0;
            divcnt_q  <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            drop_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= 1'b0;

            if (state_q == S_DIV) begin
                if (itot_q == '0) begin
                    h_q     <= '0;
                    k_q     <= '0;
                    zero_q  <= 1'b1;
                    state_q <= S_DONE;
                    irq_q   <= irq_en_q;
                end else begin
                    rem_x_q  <= rem_x_nx;
                    rem_y_q  <= rem_y_nx;
                    quot_x_q <= quot_x_nx;
                    quot_y_q <= quot_y_nx;
                    divcnt_q <= divcnt_q - 1'b1;
                    if (divcnt_q == '0) begin
                        h_q     <= quot_x_nx[CNT_W-1:0];
                        k_q     <= quot_y_nx[CNT_W-1:0];
                        state_q <= S_DONE;
                        irq_q   <= irq_en_q;
                    end
                end
            end

            // Register writes come last so START overrides any divider step.
            if (wr_en) begin
                case (addr)
                    A_CTRL: begin
`ifdef SUN_CENTROID_IRQ_EN
                        irq_en_q <= pwdatas[1];
`endif
                        if (pwdatas[0]) begin
                            sumx_q    <= '0;
                            sumy_q    <= '0;
                            itot_q    <= '0;
                            h_q       <= '0;
                            k_q       <= '0;
                            rem_x_q   <= '0;
                            rem_y_q   <= '0;
                            quot_x_q  <= '0;
                            quot_y_q  <= '0;
                            divcnt_q  <= DC_LAST;
                            xcnt_q    <= CNT_ONE;
                            ycnt_q    <= CNT_ONE;
                            ovf_q     <= 1'b0;
                            zero_q    <= 1'b0;
                            drop_q    <= 1'b0;
                            irq_q     <= 1'b0;
                            if (xmax_q == '0 || ymax_q == '0) begin
                                cfg_err_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else begin
                                cfg_err_q <= 1'b0;
                                state_q   <= S_ACCUM;
                            end
                        end else if (pwdatas[2]) begin
                            ovf_q     <= 1'b0;
                            zero_q    <= 1'b0;
                            drop_q    <= 1'b0;
                            cfg_err_q <= 1'b0;
                            if (state_q == S_DONE) state_q <= S_IDLE;
                        end
                    end
                    A_THRESH: if (state_q != S_ACCUM && state_q != S_DIV) thresh_q <= pwdatas[PIX_W-1:0];
                    A_XMAX:   if (state_q != S_ACCUM && state_q != S_DIV) xmax_q   <= pwdatas[CNT_W-1:0];
                    A_YMAX:   if (state_q != S_ACCUM && state_q != S_DIV) ymax_q   <= pwdatas[CNT_W-1:0];
                    A_PIXEL: begin
                        if (state_q == S_ACCUM) begin
                            sumx_q <= sumx_nx;
                            sumy_q <= sumy_nx;
                            itot_q <= itot_nx;
                            if (acc_ovf) ovf_q <= 1'b1;
                            if (xcnt_q == xmax_q) begin
                                xcnt_q <= CNT_ONE;
                                if (ycnt_q == ymax_q) state_q <= S_DIV;
                                else                  ycnt_q  <= ycnt_q + 1'b1;
                            end else begin
                                xcnt_q <= xcnt_q + 1'b1;
                            end
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sun_centroid_apb.sv
module tb_sun_centroid_apb;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
`ifdef SUN_CENTROID_IRQ_EN
    logic        irq0, irq1;
    int          irq_cnt = 0;
    int          irq_snap;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    sun_centroid_apb dut0 (
        .pclk(pclk), .presetn(presetn), .psels(psel[0]), .penables(penable),
        .pwrites(pwrite), .paddrs(paddr), .pwdatas(pwdata),
        .prdatas(prdata0), .preadys(pready0)
`ifdef SUN_CENTROID_IRQ_EN
        , .irqs(irq0)
`endif
    );

    sun_centroid_apb #(.PIX_W(8), .CNT_W(10), .ACC_W(24)) dut1 (
        .pclk(pclk), .presetn(presetn), .psels(psel[1]), .penables(penable),
        .pwrites(pwrite), .paddrs(paddr), .pwdatas(pwdata),
        .prdatas(prdata1), .preadys(pready1)
`ifdef SUN_CENTROID_IRQ_EN
        , .irqs(irq1)
`endif
    );

`ifdef SUN_CENTROID_IRQ_EN
    always @(negedge pclk) if (irq0 === 1'b1) irq_cnt++;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int u, input logic [7:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 2'b00; psel[u] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = {24'h0, a}; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        #1;
        psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Read; the access-phase sample reflects state after one more clock edge.
    task automatic rd(input int u, input logic [7:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        r;
        @(negedge pclk);
        psel = 2'b00; psel[u] = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = {24'h0, a};
        #1;
        r = (u == 0) ? pready0 : pready1;
        chk({tag, "_setup_rdy"}, {31'h0, r}, 32'h0);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        d = (u == 0) ? prdata0 : prdata1;
        r = (u == 0) ? pready0 : pready1;
        chk({tag, "_rdy"}, {31'h0, r}, 32'h1);
        chk(tag, d, exp);
        @(posedge pclk);
        #1;
        psel = 2'b00; penable = 1'b0;
    endtask

    task automatic frame_0_20_0_40();
        wr(0, 8'h04, 32'd0);
        wr(0, 8'h04, 32'd20);
        wr(0, 8'h04, 32'd0);
        wr(0, 8'h04, 32'd40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        // Reset state
        chk("rst_ready_idle", {31'h0, pready0}, 32'h0);
        chk("rst_prdata_idle", prdata0, 32'h0);
        rd(0, 8'h05, 32'h01, "rst_status");
        rd(0, 8'h06, 32'h0, "rst_sumx");

        // Pixel before START is dropped
        wr(0, 8'h04, 32'h33);
        rd(0, 8'h05, 32'h41, "drop_status");
        rd(0, 8'h06, 32'h0, "drop_sumx");
        wr(0, 8'h00, 32'h04);
        rd(0, 8'h05, 32'h01, "clr_status");

        // Reference frame, irq disabled
        wr(0, 8'h01, 32'd10);
        wr(0, 8'h02, 32'd2);
        wr(0, 8'h03, 32'd2);
        rd(0, 8'h01, 32'd10, "thresh_rb");
        rd(0, 8'h02, 32'd2, "xmax_rb");
        rd(0, 8'h0B, 32'h0, "unmapped_rd");
        wr(0, 8'h00, 32'h01);
        rd(0, 8'h05, 32'h02, "start_status");
        wr(0, 8'h01, 32'd99);
        rd(0, 8'h01, 32'd10, "thresh_locked");
`ifdef SUN_CENTROID_IRQ_EN
        irq_snap = irq_cnt;
`endif
        wr(0, 8'h04, 32'd0);
        wr(0, 8'h04, 32'd20);
        rd(0, 8'h06, 32'd40, "partial_sumx");
        rd(0, 8'h0A, 32'd20, "partial_itot");
        wr(0, 8'h04, 32'd0);
        wr(0, 8'h04, 32'd40);
        repeat (30) @(posedge pclk);
        rd(0, 8'h05, 32'h04, "div_at_31");
        rd(0, 8'h06, 32'd120, "f1_sumx");
        rd(0, 8'h07, 32'd100, "f1_sumy");
        rd(0, 8'h0A, 32'd60, "f1_itot");
        rd(0, 8'h05, 32'h08, "f1_status");
        rd(0, 8'h08, 32'd2, "f1_h");
        rd(0, 8'h09, 32'd1, "f1_k");
`ifdef SUN_CENTROID_IRQ_EN
        chk("irq_off_cnt", irq_cnt - irq_snap, 32'd0);
        wr(0, 8'h00, 32'h03);
        rd(0, 8'h00, 32'h02, "ctrl_irq_rb");
        irq_snap = irq_cnt;
`else
        wr(0, 8'h00, 32'h03);
        rd(0, 8'h00, 32'h00, "ctrl_rb");
`endif

        // Same frame restarted from DONE; DONE lands exactly 32 edges after last pixel
        frame_0_20_0_40();
        repeat (31) @(posedge pclk);
        rd(0, 8'h05, 32'h08, "done_at_32");
        rd(0, 8'h08, 32'd2, "f2_h");
`ifdef SUN_CENTROID_IRQ_EN
        chk("irq_on_cnt", irq_cnt - irq_snap, 32'd1);
`endif

        // Bad configuration
        wr(0, 8'h00, 32'h04);
        rd(0, 8'h05, 32'h01, "done_to_idle");
        wr(0, 8'h02, 32'd0);
        wr(0, 8'h00, 32'h01);
        rd(0, 8'h05, 32'h81, "cfg_err");

        // Zero-intensity frame: pixel equal to threshold contributes nothing
        wr(0, 8'h01, 32'd50);
        wr(0, 8'h02, 32'd1);
        wr(0, 8'h03, 32'd1);
        wr(0, 8'h00, 32'h01);
        wr(0, 8'h04, 32'd50);
        rd(0, 8'h05, 32'h28, "zero_status");
        rd(0, 8'h0A, 32'd0, "zero_itot");
        rd(0, 8'h08, 32'd0, "zero_h");
        rd(0, 8'h09, 32'd0, "zero_k");
        wr(0, 8'h04, 32'd77);
        rd(0, 8'h05, 32'h68, "done_drop");

        // Saturation on the 24-bit instance
        wr(1, 8'h01, 32'd0);
        wr(1, 8'h02, 32'd1023);
        wr(1, 8'h03, 32'd1023);
        wr(1, 8'h00, 32'h01);
        for (int i = 0; i < 400; i++) wr(1, 8'h04, 32'd255);
        rd(1, 8'h05, 32'h12, "sat_status");
        rd(1, 8'h06, 32'hFFFFFF, "sat_sumx");
        rd(1, 8'h07, 32'd102000, "sat_sumy");
        rd(1, 8'h0A, 32'd102000, "sat_itot");

        // Reset in the middle of a division
        wr(0, 8'h00, 32'h04);
        wr(0, 8'h01, 32'd10);
        wr(0, 8'h02, 32'd2);
        wr(0, 8'h03, 32'd2);
        wr(0, 8'h00, 32'h01);
        frame_0_20_0_40();
        repeat (8) @(posedge pclk);
        @(negedge pclk);
        psel = 2'b01; penable = 1'b0; pwrite = 1'b0; paddr = 32'h05;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        chk("mid_div_status", prdata0, 32'h04);
        chk("mid_div_rdy", {31'h0, pready0}, 32'h1);
        presetn = 1'b0;
        #1;
        chk("rst_prdata_now", prdata0, 32'h0);
        chk("rst_ready_now", {31'h0, pready0}, 32'h0);
`ifdef SUN_CENTROID_IRQ_EN
        chk("rst_irq_now", {31'h0, irq0}, 32'h0);
`endif
        @(negedge pclk);
        psel = 2'b00; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        rd(0, 8'h05, 32'h01, "post_rst_status");
        rd(0, 8'h08, 32'h0, "post_rst_h");
        rd(0, 8'h09, 32'h0, "post_rst_k");
        rd(0, 8'h06, 32'h0, "post_rst_sumx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
